// File: rtl/npu_pkg.sv
// Shared command codes, op codes and queue entry types for the NPU command scheduler.
package npu_pkg;

   localparam logic [7:0] CMD_EXEC      = 8'h01;
   localparam logic [7:0] CMD_RD_STATUS = 8'h02;
   localparam logic [7:0] CMD_RD_RESULT = 8'h03;
   localparam logic [7:0] CMD_FLUSH     = 8'h04;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_MAC   = 3'd3,
      OP_ADD   = 3'd4,
      OP_RELU  = 3'd5,
      OP_CLR   = 3'd6,
      OP_SYNC  = 3'd7
   } npu_op_t;

   typedef struct packed {
      npu_op_t    op;
      logic [2:0] tile_i;
      logic [2:0] tile_j;
      logic [7:0] data;
   } sched_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } sched_state_t;

   // Status byte only has room for a 3-bit occupancy field.
   function automatic logic [2:0] sat_cnt3(input int unsigned cnt);
      return (cnt > 32'd7) ? 3'd7 : cnt[2:0];
   endfunction

endpackage

// File: rtl/npu_sched_fifo.sv
// Synchronous command queue of sched_entry_t with push, pop and flush.
module npu_sched_fifo
   import npu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  sched_entry_t  wr_entry,
   output sched_entry_t  rd_entry,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   sched_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign rd_entry = mem[rd_ptr];
   assign do_pop   = pop & ~empty;
   // A push into a full queue is accepted when the head leaves in the same cycle.
   assign do_push  = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/npu_cmd_scheduler.sv
// SPI frame decoder and tile-engine issue FSM; NPU_SCHED_TIMEOUT_EN adds a req/ack abort timer.
// state | meaning
// IDLE  | no op in flight; pops the queue head when one is waiting
// REQ   | eng_req high with the current op, waiting for eng_ack
module npu_cmd_scheduler
   import npu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_valid,
   input  logic [7:0] spi_cmd,
   input  logic [2:0] spi_tile_i,
   input  logic [2:0] spi_tile_j,
   input  logic [2:0] spi_op,
   input  logic [7:0] spi_data,
   output logic [7:0] spi_data_out,
   output logic       eng_req,
   output logic [2:0] eng_op,
   output logic [2:0] eng_tile_i,
   output logic [2:0] eng_tile_j,
   output logic [7:0] eng_wdata,
   input  logic       eng_ack,
   input  logic [7:0] eng_rdata,
   output logic       busy,
   output logic       err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_param
      $error("npu_cmd_scheduler: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT in 1..256");
   end

   sched_state_t  state;
   logic [2:0]    vsync;
   logic          strobe;
   logic          is_exec, is_status, is_result, is_flush, is_ill;
   logic          pop, ovf;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;
   sched_entry_t  wr_entry, rd_entry;
   logic          err_ill, err_ovf, err_to;
   logic [7:0]    result_reg;
   logic [7:0]    status_byte;

   // Two flops synchronise, the third keeps history for the rising-edge strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) vsync <= '0;
      else     vsync <= {vsync[1:0], spi_valid};
   end
   assign strobe = vsync[1] & ~vsync[2];

   always_comb begin
      is_exec   = 1'b0;
      is_status = 1'b0;
      is_result = 1'b0;
      is_flush  = 1'b0;
      is_ill    = 1'b0;
      if (strobe) begin
         case (spi_cmd)
            CMD_EXEC:      is_exec   = 1'b1;
            CMD_RD_STATUS: is_status = 1'b1;
            CMD_RD_RESULT: is_result = 1'b1;
            CMD_FLUSH:     is_flush  = 1'b1;
            default:       is_ill    = 1'b1;
         endcase
      end
   end

   assign wr_entry = '{op: npu_op_t'(spi_op), tile_i: spi_tile_i, tile_j: spi_tile_j, data: spi_data};
   assign pop      = (state == IDLE) & ~fifo_empty;
   assign ovf      = is_exec & fifo_full & ~pop;

   npu_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (is_exec),
      .pop      (pop),
      .flush    (is_flush),
      .wr_entry (wr_entry),
      .rd_entry (rd_entry),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   assign busy        = (state == REQ) | ~fifo_empty;
   assign err         = err_ill | err_ovf | err_to;
   assign status_byte = {err_ill, err_ovf, err_to, busy, fifo_full, sat_cnt3(32'(fifo_cnt))};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_data_out <= '0;
         err_ill      <= 1'b0;
         err_ovf      <= 1'b0;
      end else begin
         if (is_status) begin
            spi_data_out <= status_byte;
            err_ill      <= 1'b0;
            err_ovf      <= 1'b0;
         end
         if (is_result) spi_data_out <= result_reg;
         if (is_ill)    err_ill <= 1'b1;
         if (ovf)       err_ovf <= 1'b1;
      end
   end

`ifdef NPU_SCHED_TIMEOUT_EN
   logic [7:0] to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         eng_req    <= 1'b0;
         eng_op     <= '0;
         eng_tile_i <= '0;
         eng_tile_j <= '0;
         eng_wdata  <= '0;
         result_reg <= '0;
         to_cnt     <= '0;
         err_to     <= 1'b0;
      end else begin
         // A timeout landing on a status read stays set so it is not lost.
         if (is_status) err_to <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               state      <= REQ;
               eng_req    <= 1'b1;
               eng_op     <= rd_entry.op;
               eng_tile_i <= rd_entry.tile_i;
               eng_tile_j <= rd_entry.tile_j;
               eng_wdata  <= rd_entry.data;
               to_cnt     <= 8'(TIMEOUT - 1);
            end
            REQ: if (eng_ack) begin
               state      <= IDLE;
               eng_req    <= 1'b0;
               result_reg <= eng_rdata;
            end else if (to_cnt == 8'd0) begin
               state      <= IDLE;
               eng_req    <= 1'b0;
               result_reg <= 8'hFF;
               err_to     <= 1'b1;
            end else begin
               to_cnt <= to_cnt - 8'd1;
            end
         endcase
      end
   end
`else
   assign err_to = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         eng_req    <= 1'b0;
         eng_op     <= '0;
         eng_tile_i <= '0;
         eng_tile_j <= '0;
         eng_wdata  <= '0;
         result_reg <= '0;
      end else begin
         case (state)
            IDLE: if (pop) begin
               state      <= REQ;
               eng_req    <= 1'b1;
               eng_op     <= rd_entry.op;
               eng_tile_i <= rd_entry.tile_i;
               eng_tile_j <= rd_entry.tile_j;
               eng_wdata  <= rd_entry.data;
            end
            REQ: if (eng_ack) begin
               state      <= IDLE;
               eng_req    <= 1'b0;
               result_reg <= eng_rdata;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// Self-checking bench for npu_cmd_scheduler: directed tables plus a queue-based reference model.
`timescale 1ns/1ps
module tb_npu_cmd_scheduler;
   import npu_pkg::*;

   localparam int DEPTH = 4;
   localparam int TO    = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_valid = 1'b0;
   logic [7:0] spi_cmd = '0;
   logic [2:0] spi_tile_i = '0, spi_tile_j = '0, spi_op = '0;
   logic [7:0] spi_data = '0;
   logic [7:0] spi_data_out;
   logic       eng_req;
   logic [2:0] eng_op, eng_tile_i, eng_tile_j;
   logic [7:0] eng_wdata;
   logic       eng_ack = 1'b0;
   logic [7:0] eng_rdata = '0;
   logic       busy, err;

   always #5 clk = ~clk;

   npu_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .spi_valid(spi_valid), .spi_cmd(spi_cmd),
      .spi_tile_i(spi_tile_i), .spi_tile_j(spi_tile_j), .spi_op(spi_op),
      .spi_data(spi_data), .spi_data_out(spi_data_out), .eng_req(eng_req),
      .eng_op(eng_op), .eng_tile_i(eng_tile_i), .eng_tile_j(eng_tile_j),
      .eng_wdata(eng_wdata), .eng_ack(eng_ack), .eng_rdata(eng_rdata),
      .busy(busy), .err(err)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [2:0] op;
      logic [2:0] ti;
      logic [2:0] tj;
      logic [7:0] d;
   } ent_t;

   ent_t       mq[$];
   ent_t       m_cur;
   bit         m_inflight;
   logic [7:0] m_res, m_out;
   bit         m_ill, m_ovf, m_to;
   int         m_wait;
   logic [2:0] vh;

   task automatic model_reset();
      mq.delete();
      m_cur = '0; m_inflight = 0; m_res = '0; m_out = '0;
      m_ill = 0; m_ovf = 0; m_to = 0; m_wait = 0; vh = '0;
   endtask

   task automatic model_step();
      bit         strobe, was_busy_op, take;
      logic [7:0] status, old_res;
      strobe  = vh[1] & ~vh[2];
      vh      = {vh[1:0], spi_valid};
      old_res = m_res;
      status  = {m_ill, m_ovf, m_to, (m_inflight || mq.size() > 0), (mq.size() == DEPTH),
                 (mq.size() > 7) ? 3'd7 : 3'(mq.size())};
      was_busy_op = m_inflight;
      take = !m_inflight && mq.size() > 0;
      if (take) begin
         m_cur = mq.pop_front();
         m_inflight = 1;
         m_wait = 0;
      end
      if (strobe) begin
         case (spi_cmd)
            CMD_EXEC:      if (mq.size() < DEPTH) mq.push_back('{spi_op, spi_tile_i, spi_tile_j, spi_data});
                           else m_ovf = 1;
            CMD_RD_STATUS: begin m_out = status; m_ill = 0; m_ovf = 0; m_to = 0; end
            CMD_RD_RESULT: m_out = old_res;
            CMD_FLUSH:     mq.delete();
            default:       m_ill = 1;
         endcase
      end
      if (was_busy_op) begin
         if (eng_ack) begin
            m_res = eng_rdata;
            m_inflight = 0;
         end
`ifdef NPU_SCHED_TIMEOUT_EN
         else begin
            m_wait++;
            if (m_wait == TO) begin
               m_res = 8'hFF; m_to = 1; m_inflight = 0;
            end
         end
`endif
      end
   endtask

   task automatic model_compare();
      chk("m_eng_req", eng_req, m_inflight);
      if (m_inflight) begin
         chk("m_eng_op", eng_op, m_cur.op);
         chk("m_eng_tile_i", eng_tile_i, m_cur.ti);
         chk("m_eng_tile_j", eng_tile_j, m_cur.tj);
         chk("m_eng_wdata", eng_wdata, m_cur.d);
      end
      chk("m_spi_data_out", spi_data_out, m_out);
      chk("m_busy", busy, (m_inflight || mq.size() > 0));
      chk("m_err", err, (m_ill || m_ovf || m_to));
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else begin
            model_step();
            #1;
            if (!rst) model_compare();
         end
      end
   end

   // ---------------- engine responder (random phase) ----------------
   bit auto_ack = 0;
   bit ack_sent = 0;
   int wait_left = 0;

   initial forever begin
      @(posedge clk);
      #2;
      if (auto_ack) begin
         eng_ack = 1'b0;
         if (eng_req && !ack_sent) begin
            if (wait_left == 0) begin
               eng_ack = 1'b1; eng_rdata = 8'($urandom); ack_sent = 1;
            end else wait_left--;
         end else if (!eng_req) begin
            ack_sent = 0;
            wait_left = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) begin
               eng_ack = 1'b1; eng_rdata = 8'($urandom);
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic frame(input logic [7:0] c, input logic [2:0] op, input logic [2:0] ti,
                        input logic [2:0] tj, input logic [7:0] d);
      spi_cmd = c; spi_op = op; spi_tile_i = ti; spi_tile_j = tj; spi_data = d;
      spi_valid = 1'b1;
      tick(4);
      spi_valid = 1'b0;
      tick(2);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic [2:0] op, ti, tj;
      logic [7:0] d;
      logic [7:0] exp_out;
      logic       exp_err;
      logic       exp_busy;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int hi;
      tbl[0]  = '{CMD_EXEC,      3'd1, 3'd0, 3'd1, 8'h11, 8'h00, 1'b0, 1'b1};
      tbl[1]  = '{CMD_EXEC,      3'd2, 3'd1, 3'd2, 8'h22, 8'h00, 1'b0, 1'b1};
      tbl[2]  = '{CMD_EXEC,      3'd3, 3'd2, 3'd3, 8'h33, 8'h00, 1'b0, 1'b1};
      tbl[3]  = '{CMD_EXEC,      3'd4, 3'd3, 3'd4, 8'h44, 8'h00, 1'b0, 1'b1};
      tbl[4]  = '{CMD_EXEC,      3'd5, 3'd4, 3'd5, 8'h55, 8'h00, 1'b0, 1'b1};
      tbl[5]  = '{CMD_EXEC,      3'd6, 3'd5, 3'd6, 8'h66, 8'h00, 1'b1, 1'b1};
      tbl[6]  = '{CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00, 8'h5C, 1'b0, 1'b1};
      tbl[7]  = '{CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00, 8'h1C, 1'b0, 1'b1};
      tbl[8]  = '{8'h7E,         3'd7, 3'd7, 3'd7, 8'hEE, 8'h1C, 1'b1, 1'b1};
      tbl[9]  = '{CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00, 8'h9C, 1'b0, 1'b1};
      tbl[10] = '{CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00, 8'h1C, 1'b0, 1'b1};

      tick(3);
      rst = 1'b0;
      tick(2);
      chk("rst_eng_req", eng_req, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_spi_data_out", spi_data_out, 8'h00);

      // Single EXEC: issue latency, fields, result readback.
      spi_cmd = CMD_EXEC; spi_op = 3'd3; spi_tile_i = 3'd2; spi_tile_j = 3'd5; spi_data = 8'h5A;
      spi_valid = 1'b1;
      tick(3);
      chk("t1_req_before_latency", eng_req, 1'b0);
      tick(1);
      chk("t1_req_at_latency", eng_req, 1'b1);
      chk("t1_op", eng_op, 3'd3);
      chk("t1_tile_i", eng_tile_i, 3'd2);
      chk("t1_tile_j", eng_tile_j, 3'd5);
      chk("t1_wdata", eng_wdata, 8'h5A);
      tick(3);
      eng_ack = 1'b1; eng_rdata = 8'h3C;
      tick(1);
      eng_ack = 1'b0;
      chk("t1_req_after_ack", eng_req, 1'b0);
      spi_valid = 1'b0;
      tick(2);
      frame(CMD_RD_RESULT, 3'd0, 3'd0, 3'd0, 8'h00);
      chk("t1_result", spi_data_out, 8'h3C);

      // Overflow, illegal command and read-to-clear, ack held low.
      do_reset();
      foreach (tbl[k]) begin
         frame(tbl[k].cmd, tbl[k].op, tbl[k].ti, tbl[k].tj, tbl[k].d);
         chk($sformatf("tbl%0d_out", k), spi_data_out, tbl[k].exp_out);
         chk($sformatf("tbl%0d_err", k), err, tbl[k].exp_err);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].exp_busy);
      end

      // FLUSH with one op in flight and three queued.
      do_reset();
      for (int k = 0; k < 4; k++) frame(CMD_EXEC, 3'(k), 3'(k), 3'(k + 1), 8'(8'hA0 + k));
      frame(CMD_FLUSH, 3'd0, 3'd0, 3'd0, 8'h00);
      frame(CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00);
      chk("t4_status_after_flush", spi_data_out, 8'h10);
      chk("t4_req_still_high", eng_req, 1'b1);
      eng_ack = 1'b1; eng_rdata = 8'hA7;
      tick(1);
      eng_ack = 1'b0;
      chk("t4_busy_after_ack", busy, 1'b0);
      tick(3);
      chk("t4_no_reissue", eng_req, 1'b0);
      frame(CMD_RD_RESULT, 3'd0, 3'd0, 3'd0, 8'h00);
      chk("t4_result", spi_data_out, 8'hA7);

`ifdef NPU_SCHED_TIMEOUT_EN
      // Timeout abort, then the next queued op issues.
      do_reset();
      spi_cmd = CMD_EXEC; spi_op = 3'd1; spi_tile_i = 3'd1; spi_tile_j = 3'd1; spi_data = 8'h01;
      spi_valid = 1'b1;
      tick(4);
      hi = 0;
      while (eng_req === 1'b1 && hi < 40) begin hi++; tick(1); end
      spi_valid = 1'b0;
      chk("t5_req_high_cycles", hi, TO);
      chk("t5_err_to", err, 1'b1);
      tick(2);
      frame(CMD_EXEC, 3'd2, 3'd2, 3'd2, 8'h02);
      chk("t5_next_issue", eng_req, 1'b1);
      chk("t5_next_wdata", eng_wdata, 8'h02);
      frame(CMD_RD_RESULT, 3'd0, 3'd0, 3'd0, 8'h00);
      chk("t5_result_ff", spi_data_out, 8'hFF);
      eng_ack = 1'b1; eng_rdata = 8'h77;
      tick(1);
      eng_ack = 1'b0;
      tick(2);
`endif

      // Async reset while an op is in flight with two queued.
      do_reset();
      for (int k = 0; k < 3; k++) frame(CMD_EXEC, 3'd4, 3'(k), 3'(k), 8'(8'hC0 + k));
      chk("t6_req_before_rst", eng_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_req_in_rst", eng_req, 1'b0);
      chk("t6_busy_in_rst", busy, 1'b0);
      @(posedge clk); #1;
      tick(1);
      rst = 1'b0;
      tick(3);
      chk("t6_busy_after_rst", busy, 1'b0);
      chk("t6_req_after_rst", eng_req, 1'b0);
      frame(CMD_RD_STATUS, 3'd0, 3'd0, 3'd0, 8'h00);
      chk("t6_status_empty", spi_data_out, 8'h00);

      // Random frames against the reference model.
      do_reset();
      auto_ack = 1;
      for (int n = 0; n < 300; n++) begin
         int r;
         logic [7:0] c;
         r = $urandom_range(0, 9);
         if (r < 5)       c = CMD_EXEC;
         else if (r == 5) c = CMD_RD_STATUS;
         else if (r == 6) c = CMD_RD_RESULT;
         else if (r == 7) c = CMD_FLUSH;
         else             c = 8'($urandom_range(5, 255));
         frame(c, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
         tick($urandom_range(0, 3));
      end
      auto_ack = 0;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
